// File: rtl/memory_bus_arbiter.sv
// Two-port (fetch / data) arbiter for the single core memory bus.
// Grants are round-robin on ties, held until bus completion, and bounded by a watchdog.
module memory_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMER_WIDTH    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        f_valid,
  output logic        f_ready,
  input  logic [31:0] f_address,
  output logic [31:0] f_rdata,
  output logic        f_error,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_address,
  input  logic [3:0]  d_wstrobe,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_error,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_address,
  output logic [3:0]  m_wstrobe,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, GRANT_F, GRANT_D} state_t;

  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
    TIMER_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                 state;
  logic                   last_d;
  logic [TIMER_WIDTH-1:0] timer;
  logic                   gnt_f;
  logic                   gnt_d;
  logic                   timeout;
  logic                   done;

  assign gnt_f   = (state == GRANT_F);
  assign gnt_d   = (state == GRANT_D);
  // A real m_ready in the last watchdog cycle wins over the forced termination.
  assign timeout = WD_EN && (gnt_f || gnt_d) && !m_ready && (timer == TIMER_LAST);
  assign done    = (gnt_f || gnt_d) && (m_ready || timeout);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      last_d  <= 1'b1;
      timer   <= '0;
      m_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          // Tie goes to whichever port was not granted last.
          if (f_valid && (!d_valid || last_d)) begin
            state   <= GRANT_F;
            last_d  <= 1'b0;
            m_valid <= 1'b1;
          end else if (d_valid) begin
            state   <= GRANT_D;
            last_d  <= 1'b1;
            m_valid <= 1'b1;
          end
        end
        GRANT_F, GRANT_D: begin
          if (done) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            timer   <= '0;
          end else if (WD_EN) begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
          timer   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    m_address = '0;
    m_wstrobe = '0;
    m_wdata   = '0;
    if (gnt_f) begin
      m_address = f_address;
    end else if (gnt_d) begin
      m_address = d_address;
      m_wstrobe = d_wstrobe;
      m_wdata   = d_wdata;
    end
  end

  always_comb begin
    f_ready = gnt_f && (m_ready || timeout);
    f_error = gnt_f && timeout;
    f_rdata = (gnt_f && m_ready) ? m_rdata : '0;
    d_ready = gnt_d && (m_ready || timeout);
    d_error = gnt_d && timeout;
    d_rdata = (gnt_d && m_ready) ? m_rdata : '0;
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench for memory_bus_arbiter: a transaction-level model predicts grant
// order and responses; a bus responder and an output monitor run independently.
module tb_memory_bus_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        f_valid = 1'b0, d_valid = 1'b0;
  logic [31:0] f_address = '0, d_address = '0, d_wdata = '0;
  logic [3:0]  d_wstrobe = '0;
  logic        f_ready, f_error, d_ready, d_error;
  logic [31:0] f_rdata, d_rdata;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_address, m_wdata;
  logic [3:0]  m_wstrobe;
  logic [31:0] m_rdata = '0;

  memory_bus_arbiter #(.TIMEOUT_CYCLES(TMO), .TIMER_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .f_valid(f_valid), .f_ready(f_ready), .f_address(f_address),
    .f_rdata(f_rdata), .f_error(f_error),
    .d_valid(d_valid), .d_ready(d_ready), .d_address(d_address),
    .d_wstrobe(d_wstrobe), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_error(d_error),
    .m_valid(m_valid), .m_ready(m_ready), .m_address(m_address),
    .m_wstrobe(m_wstrobe), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] bus_rdata;
    logic [31:0] rdata;
    bit          err;
    int          ncyc;
  } txn_t;

  txn_t exp_q[$];
  txn_t bus_q[$];

  int checks = 0;
  int errors = 0;
  bit model_last_d = 1'b1;
  bit mon_en = 1'b0;
  bit hold_bus = 1'b1;
  bit f_done = 1'b0, d_done = 1'b0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic txn_t make_txn(input bit is_d, input logic [31:0] addr, input logic [3:0] strb,
                                    input logic [31:0] wdata, input int delay, input logic [31:0] rd);
    txn_t t;
    t.is_d      = is_d;
    t.addr      = addr;
    t.strb      = is_d ? strb : 4'h0;
    t.wdata     = is_d ? wdata : 32'h0;
    t.delay     = delay;
    t.bus_rdata = rd;
    // Bus answers on transfer cycle delay+1; the watchdog ends it after TMO cycles.
    t.err       = (delay + 1 > TMO);
    t.rdata     = t.err ? 32'h0 : rd;
    t.ncyc      = t.err ? TMO : delay + 1;
    return t;
  endfunction

  // Bus responder: per grant, raises m_ready on the planned cycle; noise while idle.
  initial begin
    txn_t cur;
    int rcnt = 0;
    cur = make_txn(1'b0, 0, 0, 0, 1000, 0);
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n || hold_bus) begin
        m_ready = 1'b0;
        rcnt = 0;
      end else if (m_valid) begin
        if (rcnt == 0) begin
          if (bus_q.size() > 0) cur = bus_q.pop_front();
          else cur = make_txn(1'b0, 0, 0, 0, 1000, 0);
        end
        rcnt++;
        m_ready = (rcnt == cur.delay + 1);
        m_rdata = m_ready ? cur.bus_rdata : $urandom;
      end else begin
        rcnt = 0;
        m_ready = 1'($urandom_range(0, 1));
        m_rdata = $urandom;
      end
    end
  end

  // Output monitor: compares bus-side fields and requester responses to the scoreboard.
  initial begin
    int  mcnt = 0;
    bit  prev_done = 1'b0;
    txn_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        mcnt = 0;
        prev_done = 1'b0;
      end else begin
        if (prev_done) check(!m_valid, "idle_bubble", {31'd0, m_valid}, 32'd0);
        prev_done = 1'b0;
        if (m_valid) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_grant", m_address, 32'd0);
          end else begin
            e = exp_q[0];
            mcnt++;
            if (mcnt == 1) begin
              check(m_address == e.addr, "m_address", m_address, e.addr);
              check(m_wstrobe == e.strb, "m_wstrobe", {28'd0, m_wstrobe}, {28'd0, e.strb});
              check(m_wdata == e.wdata, "m_wdata", m_wdata, e.wdata);
            end
            if (e.is_d) check(!f_ready && f_rdata == 0 && !f_error, "ungranted_f", f_rdata, 32'd0);
            else        check(!d_ready && d_rdata == 0 && !d_error, "ungranted_d", d_rdata, 32'd0);
            if (f_ready || d_ready) begin
              e = exp_q.pop_front();
              check(d_ready == e.is_d, "ready_port", {31'd0, d_ready}, {31'd0, e.is_d});
              check((e.is_d ? d_rdata : f_rdata) == e.rdata, "rdata",
                    e.is_d ? d_rdata : f_rdata, e.rdata);
              check((e.is_d ? d_error : f_error) == e.err, "error",
                    {31'd0, e.is_d ? d_error : f_error}, {31'd0, e.err});
              check(mcnt == e.ncyc, "txn_cycles", mcnt, e.ncyc);
              if (e.is_d) d_done = 1'b1; else f_done = 1'b1;
              mcnt = 0;
              prev_done = 1'b1;
            end
          end
        end else if (m_ready) begin
          check(!f_ready && !d_ready, "late_m_ready_ignored", {30'd0, f_ready, d_ready}, 32'd0);
        end
      end
    end
  end

  task automatic push_txn(input txn_t t);
    exp_q.push_back(t);
    bus_q.push_back(t);
  endtask

  task automatic do_round(input bit rf, input bit rd, input logic [31:0] fa, input logic [31:0] da,
                          input logic [3:0] ds, input logic [31:0] dw,
                          input int dlf, input logic [31:0] rdf, input int dld, input logic [31:0] rdd);
    txn_t tf, td;
    int budget;
    tf = make_txn(1'b0, fa, 0, 0, dlf, rdf);
    td = make_txn(1'b1, da, ds, dw, dld, rdd);
    if (rf && rd) begin
      if (model_last_d) begin push_txn(tf); push_txn(td); end
      else begin push_txn(td); push_txn(tf); end
    end else if (rf) begin
      push_txn(tf); model_last_d = 1'b0;
    end else if (rd) begin
      push_txn(td); model_last_d = 1'b1;
    end
    f_address = fa; d_address = da; d_wstrobe = ds; d_wdata = dw;
    f_valid = rf; d_valid = rd;
    @(posedge clk);
    #1;
    check(m_valid == 1'b1, "grant_latency", {31'd0, m_valid}, 32'd1);
    budget = 100;
    while ((f_valid || d_valid) && budget > 0) begin
      @(posedge clk);
      #1;
      if (f_done) begin f_valid = 1'b0; f_done = 1'b0; end
      if (d_done) begin d_valid = 1'b0; d_done = 1'b0; end
      budget--;
    end
    if (budget == 0) begin
      check(1'b0, "round_timeout", {30'd0, f_valid, d_valid}, 32'd0);
      f_valid = 1'b0; d_valid = 1'b0;
    end
  endtask

  initial begin
    bit rf, rd;
    #2;
    check(!m_valid && !f_ready && !d_ready && !f_error && !d_error, "reset_ctrl",
          {27'd0, m_valid, f_ready, d_ready, f_error, d_error}, 32'd0);
    check(m_address == 0 && m_wstrobe == 0 && m_wdata == 0, "reset_bus", m_address | m_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    hold_bus = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    do_round(1, 0, 32'h100, 0, 0, 0, 2, 32'h13, 0, 0);
    do_round(0, 1, 0, 32'h2002, 4'b1100, 32'hABCDABCD, 0, 0, 0, 32'h5A5A5A5A);
    do_round(1, 1, 32'h200, 32'h3000, 4'b0000, 0, 0, 32'h11, 0, 32'h22);
    do_round(1, 1, 32'h204, 32'h3004, 4'b0001, 32'h77777777, 0, 32'h33, 0, 32'h44);
    do_round(0, 1, 0, 32'h4000, 4'b1111, 32'h12345678, 0, 0, 10, 32'hDEADBEEF);
    do_round(0, 1, 0, 32'h4004, 4'b1111, 32'h87654321, 0, 0, TMO - 1, 32'hCAFEF00D);
    do_round(1, 0, 32'h300, 0, 0, 0, TMO, 32'h99, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rf = 1'($urandom_range(0, 1));
      rd = rf ? 1'($urandom_range(0, 1)) : 1'b1;
      do_round(rf, rd, $urandom, $urandom, 4'($urandom), $urandom,
               $urandom_range(0, 6), $urandom, $urandom_range(0, 6), $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Asynchronous reset while the data port holds the bus.
    repeat (3) @(posedge clk);
    mon_en = 1'b0;
    hold_bus = 1'b1;
    #1;
    d_address = 32'h5000; d_wstrobe = 4'b0011; d_wdata = 32'h0F0F0F0F;
    d_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    m_ready = 1'b1;
    #1;
    check(m_valid && d_ready, "pre_reset_grant_d", {30'd0, m_valid, d_ready}, 32'd3);
    reset_n = 1'b0;
    #1;
    check(!m_valid && !d_ready && !d_error, "async_reset_drop", {30'd0, m_valid, d_ready}, 32'd0);
    check(m_address == 0 && m_wstrobe == 0, "async_reset_bus", m_address, 32'd0);
    d_valid = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    bus_q.delete();
    f_done = 1'b0; d_done = 1'b0;
    model_last_d = 1'b1;
    reset_n = 1'b1;
    hold_bus = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    do_round(1, 1, 32'h600, 32'h7000, 4'b0100, 32'h00AA0000, 1, 32'hF1, 0, 32'hD1);
    repeat (3) @(posedge clk);
    check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- Shares the single core memory bus between the instruction-fetch port (read-only) and the data port (load/store unit: address, wstrobe, wdata, rdata).
- Grants one requester at a time and holds the grant until the bus completes the transaction.
- Resolves simultaneous requests round-robin.
- A watchdog terminates transactions the bus never acknowledges and flags an error to the requester.

Parameters:
- TIMEOUT_CYCLES, 255, cycles with m_valid=1 and m_ready=0 before forced termination; 0 disables the watchdog.
- TIMER_WIDTH, 8, width of the watchdog counter; must satisfy TIMEOUT_CYCLES < 2**TIMER_WIDTH.

Ports:
- clk  in  1  core clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- f_valid  in  1  fetch request; held with f_address stable until f_ready
- f_ready  out  1  fetch transaction complete this cycle
- f_address  in  32  fetch address
- f_rdata  out  32  fetch read data, valid when f_ready=1
- f_error  out  1  qualifies f_ready; 1 = watchdog termination
- d_valid  in  1  data request; held with d_address/d_wstrobe/d_wdata stable until d_ready
- d_ready  out  1  data transaction complete this cycle
- d_address  in  32  data address
- d_wstrobe  in  4  byte write enables; 0 = load
- d_wdata  in  32  store data, already lane-replicated
- d_rdata  out  32  load data, valid when d_ready=1
- d_error  out  1  qualifies d_ready; 1 = watchdog termination
- m_valid  out  1  bus request
- m_ready  in  1  bus completion
- m_address  out  32  bus address
- m_wstrobe  out  4  bus byte enables; forced 0 during fetch grants
- m_wdata  out  32  bus write data
- m_rdata  in  32  bus read data

Behaviour:
- State machine, states IDLE, GRANT_F, GRANT_D.
- Reset (async assert, any state): state=IDLE, last_grant=D, timer=0. m_valid, f_ready, d_ready, f_error and d_error are 0. m_address, m_wstrobe and m_wdata are 0.
- IDLE, requests sampled at the clock edge:
  - only f_valid: go to GRANT_F.
  - only d_valid: go to GRANT_D.
  - both: grant the port not equal to last_grant. After reset, fetch wins the first tie.
  - none: stay in IDLE.
  - last_grant is updated on entry to the granted state.
- GRANT_x outputs:
  - m_valid=1.
  - m_address, m_wstrobe and m_wdata are muxed combinationally from port x; for fetch, wstrobe=0 and wdata=0.
  - Latency from x_valid rising in IDLE to m_valid is 1 cycle.
- Completion in GRANT_x:
  - When m_ready=1: x_ready=1 and x_rdata=m_rdata in the same cycle, combinational pass-through. Next state is IDLE.
  - The other port's ready stays 0.
  - Minimum transaction is 2 cycles, with one IDLE bubble before the next grant.
- Ungranted port: ready=0, error=0, rdata=0.
- Requester deasserting valid during a grant is a protocol violation. The arbiter ignores it and completes the bus transaction.
- Watchdog:
  - timer clears on grant entry.
  - It increments each GRANT cycle with m_ready=0.
  - When timer==TIMEOUT_CYCLES-1 and m_ready=0: x_ready=1, x_error=1, x_rdata=0, next state IDLE.
  - m_ready=1 in the same cycle takes precedence: normal completion, error=0.
  - A late m_ready arriving in IDLE is ignored.
  - With TIMEOUT_CYCLES=0 the timer is held at 0 and no termination occurs.
- Simultaneous new request and completion: a request arriving in the completion cycle is sampled in the following IDLE cycle, never granted mid-transaction.
- Arbitration is starvation-free: a port waiting during a grant is served next if it is still requesting.

Test Plan:
- Fetch only: f_valid=1, f_address=0x100, m_ready after 2 cycles with m_rdata=0x00000013. Required: m_valid one cycle after f_valid, m_wstrobe=0, f_ready=1 with f_rdata=0x13 and f_error=0, d_ready=0 throughout.
- Store only: d_address=0x2002, d_wstrobe=0b1100, d_wdata=0xABCDABCD, m_ready on the first m_valid cycle. Required: m_wstrobe=0b1100, m_wdata=0xABCDABCD, d_ready pulse of 1 cycle.
- Tie after reset: f_valid=d_valid=1 held through repeated transactions, m_ready=1 immediately. Required grant order F, D, F, D, each followed by one IDLE cycle.
- Watchdog: TIMEOUT_CYCLES=4, d_valid=1, m_ready held 0. Required: d_ready=1, d_error=1, d_rdata=0 on the 4th m_valid cycle, m_valid=0 the next cycle. Repeat with m_ready=1 on the 4th cycle: normal completion, d_error=0.
- Reset mid-transaction: assert reset_n=0 asynchronously in GRANT_D. Required: m_valid and d_ready drop immediately without a clock. After release, the first tie is granted to fetch.
